// File: rtl/aes_key_loader_if.sv
// Word-serial key ingest handshake: 32-bit key words with valid/ready.
interface aes_key_loader_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/aes_key_loader.sv
// AES-128 cipher-key loader: assembles four 32-bit words and commits them to a
// double-buffered key output. Optional zeroize port under AES_KEY_ZEROIZE_EN.
module aes_key_loader #(
    parameter bit AUTO_COMMIT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    aes_key_loader_if.slave        s,
    input  logic                   commit_req,
    input  logic                   clear,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic                   zeroize,
`endif
    output logic [127:0]           key_out,
    output logic                   key_valid,
    output logic                   key_update,
    output logic [1:0]             word_cnt
);
    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] stage_q, stage_d;
    logic [127:0] key_q, key_d;
    logic         kvalid_q, kvalid_d;
    logic         kupd_q, kupd_d;
    logic         zero;
    logic         accept;

`ifdef AES_KEY_ZEROIZE_EN
    assign zero = zeroize;
`else
    assign zero = 1'b0;
`endif

    assign s.s_ready = (state_q == ST_LOAD);
    assign accept    = s.s_valid && (state_q == ST_LOAD);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        key_d    = key_q;
        kvalid_d = kvalid_q;
        kupd_d   = 1'b0;
        if (zero) begin
            state_d  = ST_LOAD;
            cnt_d    = '0;
            stage_d  = '0;
            key_d    = '0;
            kvalid_d = 1'b0;
        end else if (clear) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
        end else if (state_q == ST_FULL) begin
            if (commit_req) begin
                key_d    = stage_q;
                kvalid_d = 1'b1;
                kupd_d   = 1'b1;
                state_d  = ST_LOAD;
            end
        end else if (accept) begin
            stage_d[{cnt_q, 5'd0} +: 32] = s.s_data;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                // Auto mode bypasses staging for the last word so the key lands in one edge.
                if (AUTO_COMMIT) begin
                    key_d    = {s.s_data, stage_q[95:0]};
                    kvalid_d = 1'b1;
                    kupd_d   = 1'b1;
                end else begin
                    state_d = ST_FULL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOAD;
            cnt_q    <= '0;
            stage_q  <= '0;
            key_q    <= '0;
            kvalid_q <= 1'b0;
            kupd_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            key_q    <= key_d;
            kvalid_q <= kvalid_d;
            kupd_q   <= kupd_d;
        end
    end

    assign key_out    = key_q;
    assign key_valid  = kvalid_q;
    assign key_update = kupd_q;
    assign word_cnt   = cnt_q;
endmodule

// File: tb/tb_aes_key_loader.sv
// Bench for aes_key_loader: auto-commit and held-commit instances driven by the
// same stimulus, checked every cycle against a word-count/queue model.
module tb_aes_key_loader;
    localparam logic [127:0] K1 = 128'h09cf4f3cabf7158828aed2a62b7e1516;
    localparam logic [127:0] K2 = 128'h0c0d0e0f08090a0b0405060700010203;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        commit_req = 1'b0;
    logic        clear = 1'b0;
    logic        zeroize = 1'b0;

    logic [127:0] ko [2];
    logic         kv [2];
    logic         ku [2];
    logic [1:0]   wc [2];
    logic         rdy [2];

    int checks = 0;
    int errors = 0;

    // Model: index 0 = auto-commit instance, 1 = held-commit instance
    logic [31:0]  mw [2][4];
    int unsigned  mn [2];
    logic [127:0] mkey [2];
    logic         mkv [2];
    logic         mku [2];

    always #5 clk = ~clk;

    aes_key_loader_if if_a ();
    aes_key_loader_if if_h ();
    assign if_a.s_data  = s_data;
    assign if_a.s_valid = s_valid;
    assign if_h.s_data  = s_data;
    assign if_h.s_valid = s_valid;
    assign rdy[0] = if_a.s_ready;
    assign rdy[1] = if_h.s_ready;

    aes_key_loader #(.AUTO_COMMIT(1'b1)) u_auto (
        .clk(clk), .rst_n(rst_n), .s(if_a.slave),
        .commit_req(commit_req), .clear(clear),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key_out(ko[0]), .key_valid(kv[0]), .key_update(ku[0]), .word_cnt(wc[0])
    );

    aes_key_loader #(.AUTO_COMMIT(1'b0)) u_held (
        .clk(clk), .rst_n(rst_n), .s(if_h.slave),
        .commit_req(commit_req), .clear(clear),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key_out(ko[1]), .key_valid(kv[1]), .key_update(ku[1]), .word_cnt(wc[1])
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mn[m] = 0; mkey[m] = '0; mkv[m] = 1'b0; mku[m] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            mku[m] = 1'b0;
            if (zeroize) begin
                mn[m] = 0; mkey[m] = '0; mkv[m] = 1'b0;
            end else if (clear) begin
                mn[m] = 0;
            end else if (mn[m] == 4) begin
                if (commit_req) begin
                    mkey[m] = {mw[m][3], mw[m][2], mw[m][1], mw[m][0]};
                    mkv[m] = 1'b1; mku[m] = 1'b1; mn[m] = 0;
                end
            end else if (s_valid) begin
                mw[m][mn[m]] = s_data;
                mn[m]++;
                if (mn[m] == 4 && m == 0) begin
                    mkey[m] = {mw[m][3], mw[m][2], mw[m][1], mw[m][0]};
                    mkv[m] = 1'b1; mku[m] = 1'b1; mn[m] = 0;
                end
            end
        end
    endtask

    task automatic compare();
        for (int m = 0; m < 2; m++) begin
            chk(m == 0 ? "auto.key_out" : "held.key_out", ko[m], mkey[m]);
            chk(m == 0 ? "auto.key_valid" : "held.key_valid", 128'(kv[m]), 128'(mkv[m]));
            chk(m == 0 ? "auto.key_update" : "held.key_update", 128'(ku[m]), 128'(mku[m]));
            chk(m == 0 ? "auto.word_cnt" : "held.word_cnt", 128'(wc[m]), 128'(mn[m] % 4));
            chk(m == 0 ? "auto.s_ready" : "held.s_ready", 128'(rdy[m]), 128'(mn[m] < 4));
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst_n) model_step();
            #1;
            compare();
        end
    end

    // One cycle of stimulus; returns shortly after the sampling edge.
    task automatic cyc(input bit v, input logic [31:0] d, input bit c, input bit cl, input bit z);
        @(negedge clk);
        s_valid = v; s_data = d; commit_req = c; clear = cl;
`ifdef AES_KEY_ZEROIZE_EN
        zeroize = z;
`else
        zeroize = 1'b0 & z;
`endif
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [31:0] kw1 [4];
    logic [31:0] kw2 [4];
    logic [31:0] w [4];
    logic [127:0] kb;

    initial begin
        kw1[0] = 32'h2b7e1516; kw1[1] = 32'h28aed2a6; kw1[2] = 32'habf71588; kw1[3] = 32'h09cf4f3c;
        kw2[0] = 32'h00010203; kw2[1] = 32'h04050607; kw2[2] = 32'h08090a0b; kw2[3] = 32'h0c0d0e0f;

        #12;
        chk("reset.key_out", ko[0], '0);
        chk("reset.key_valid", 128'(kv[1]), '0);
        chk("reset.word_cnt", 128'(wc[0]), '0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("post_reset.s_ready", 128'(rdy[0] & rdy[1]), 128'd1);

        // Auto commit of the reference key
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, kw1[i], 1'b0, 1'b0, 1'b0);
            chk("auto.cnt_seq", 128'(wc[0]), 128'((i + 1) % 4));
        end
        chk("auto.k1", ko[0], K1);
        chk("auto.k1_update", 128'(ku[0]), 128'd1);
        chk("auto.k1_valid", 128'(kv[0]), 128'd1);
        chk("model.k1", mkey[0], K1);
        chk("held.full_ready", 128'(rdy[1]), 128'd0);
        idle();
        chk("auto.update_one_cycle", 128'(ku[0]), 128'd0);

        // Held instance ignores words while full
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
            chk("held.key_before_commit", ko[1], '0);
            chk("held.ready_full", 128'(rdy[1]), 128'd0);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("held.k1", ko[1], K1);
        chk("held.k1_update", 128'(ku[1]), 128'd1);
        chk("held.ready_back", 128'(rdy[1]), 128'd1);

        // Clear mid-load discards the word handshaked with it
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hdeadbeef, 1'b0, 1'b1, 1'b0);
        chk("clear.word_cnt", 128'(wc[0]), '0);
        for (int i = 0; i < 4; i++) cyc(1'b1, kw2[i], 1'b0, 1'b0, 1'b0);
        chk("clear.auto_k2", ko[0], K2);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("clear.held_k2", ko[1], K2);
        chk("model.k2", mkey[1], K2);

        // Double buffering: partial key B with gaps never disturbs key A
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        kb = {w[3], w[2], w[1], w[0]};
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("dbuf.hold_a", ko[0], K2);
            cyc(1'b1, w[i], 1'b0, 1'b0, 1'b0);
            chk("dbuf.auto", ko[0], (i < 3) ? K2 : kb);
        end
        chk("dbuf.held_hold_a", ko[1], K2);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("dbuf.held_b", ko[1], kb);

        // Asynchronous reset mid-load
        for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        s_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("areset.key_out", ko[0] | ko[1], '0);
        chk("areset.key_valid", 128'(kv[0] | kv[1]), '0);
        chk("areset.word_cnt", 128'(wc[0] | wc[1]), '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        kb = {w[3], w[2], w[1], w[0]};
        for (int i = 0; i < 4; i++) cyc(1'b1, w[i], 1'b0, 1'b0, 1'b0);
        chk("areset.fresh_key", ko[0], kb);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("areset.held_fresh", ko[1], kb);

`ifdef AES_KEY_ZEROIZE_EN
        for (int i = 0; i < 4; i++) cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("zeroize.key_out", ko[1], '0);
        chk("zeroize.key_valid", 128'(kv[1]), '0);
        chk("zeroize.key_update", 128'(ku[1]), '0);
        chk("zeroize.s_ready", 128'(rdy[1]), 128'd1);
        chk("zeroize.auto_key", ko[0], '0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) < 60), $urandom,
                ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 4),
                ($urandom_range(0, 99) < 2));
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
